// File: rtl/laser_pkg.sv
// Shared types and constants for the LASER two-circle coverage search
// (16x16 candidate grid, radius-4 circles).
package laser_pkg;
  localparam int GRID      = 16;
  localparam int RADIUS_SQ = 16;
  localparam int NPTS_DEF  = 40;
  localparam int ADDR_W    = 6;
  localparam int CNT_W     = 6;

  typedef enum logic [1:0] {IDLE, SCAN, UPDATE, FIN} state_t;

  // Packed {y,x}: a plain increment walks the grid X-fastest with the Y carry.
  typedef struct packed {
    logic [3:0] y;
    logic [3:0] x;
  } point_t;

  function automatic logic is_last_cand(input point_t p);
    return (p.x == 4'(GRID - 1)) && (p.y == 4'(GRID - 1));
  endfunction
endpackage

// File: rtl/laser_best_tracker.sv
// Per-candidate hit accumulator and strict-greater best-candidate register;
// ties keep the earlier candidate in raster order.
module laser_best_tracker
  import laser_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             hit_vld,
  input  logic             hit,
  input  logic             last_pt,
  input  point_t           cand_xy,
  output logic [CNT_W-1:0] best_cnt,
  output point_t           best_xy
);

  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] cnt_now;

  assign cnt_now = acc + CNT_W'(hit);

  // acc returns to zero after each candidate's last point, so the next hit starts a fresh count
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc      <= '0;
      best_cnt <= '0;
      best_xy  <= '0;
    end else if (clr) begin
      acc      <= '0;
      best_cnt <= '0;
      best_xy  <= '0;
    end else if (hit_vld) begin
      if (last_pt) begin
        acc <= '0;
        if (cnt_now > best_cnt) begin
          best_cnt <= cnt_now;
          best_xy  <= cand_xy;
        end
      end else begin
        acc <= cnt_now;
      end
    end
  end

endmodule

// File: rtl/laser_scan_ctrl.sv
// Sequencer for the LASER two-circle search: raster-scans every candidate
// centre against the point buffer and alternates C1/C2 until coverage settles.
module laser_scan_ctrl
  import laser_pkg::*;
#(
  parameter int NPTS       = NPTS_DEF,
  parameter int MAX_PASSES = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  output logic [ADDR_W-1:0] pt_addr,
  output logic [3:0]        cand_x,
  output logic [3:0]        cand_y,
  output logic [3:0]        fixed_x,
  output logic [3:0]        fixed_y,
  output logic              fixed_en,
  input  logic              hit_cand,
  input  logic              hit_fixed,
  output logic              busy,
  output logic [3:0]        C1X,
  output logic [3:0]        C1Y,
  output logic [3:0]        C2X,
  output logic [3:0]        C2Y,
  output logic              DONE
);

  localparam int                PASS_W    = $clog2(MAX_PASSES + 1);
  localparam logic [ADDR_W-1:0] LAST_PT   = ADDR_W'(NPTS - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(MAX_PASSES - 1);

  state_t            state, state_d;
  logic [ADDR_W-1:0] pt;
  point_t            cand;
  logic              drain;
  logic [PASS_W-1:0] pass;
  logic [CNT_W-1:0]  prev_total;
  point_t            c1, c2;
  logic              addr_vld, accept, scan_enter, do_update, stop, fin;
  logic              vld_p1, last_p1;
  point_t            cand_p1;
  logic [CNT_W-1:0]  best_cnt;
  point_t            best_xy;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d    = state;
    accept     = 1'b0;
    scan_enter = 1'b0;
    do_update  = 1'b0;
    stop       = 1'b0;
    fin        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d    = SCAN;
          accept     = 1'b1;
          scan_enter = 1'b1;
        end
      end
      SCAN: begin
        if (drain) state_d = UPDATE;
      end
      UPDATE: begin
        do_update = 1'b1;
        stop = ((pass >= PASS_W'(2)) && (best_cnt == prev_total)) || (pass == LAST_PASS);
        if (stop) begin
          state_d = FIN;
        end else begin
          state_d    = SCAN;
          scan_enter = 1'b1;
        end
      end
      FIN: begin
        fin     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Addresses are issued until the last point of the last candidate; one drain cycle follows for its hit
  assign addr_vld = (state == SCAN) && !drain;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pt    <= '0;
      cand  <= '0;
      drain <= 1'b0;
    end else if (scan_enter) begin
      pt    <= '0;
      cand  <= '0;
      drain <= 1'b0;
    end else if (addr_vld) begin
      if (pt == LAST_PT) begin
        pt <= '0;
        if (is_last_cand(cand)) drain <= 1'b1;
        else                    cand  <= point_t'(cand + 8'd1);
      end else begin
        pt <= pt + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pass       <= '0;
      prev_total <= '0;
      c1         <= '0;
      c2         <= '0;
    end else if (accept) begin
      pass       <= '0;
      prev_total <= '0;
      c1         <= '0;
      c2         <= '0;
    end else if (do_update) begin
      pass       <= pass + PASS_W'(1);
      prev_total <= best_cnt;
      if (pass[0]) c2 <= best_xy;
      else         c1 <= best_xy;
    end
  end

  // p0 -> p1: hits return one cycle after the address, so tag them with the issuing point/candidate
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) vld_p1 <= 1'b0;
    else     vld_p1 <= addr_vld;
  end

  always_ff @(posedge CLK) begin
    last_p1 <= (pt == LAST_PT);
    cand_p1 <= cand;
  end

  laser_best_tracker u_tracker (
    .CLK      (CLK),
    .RST      (RST),
    .clr      (scan_enter),
    .hit_vld  (vld_p1),
    .hit      (hit_cand | hit_fixed),
    .last_pt  (last_p1),
    .cand_xy  (cand_p1),
    .best_cnt (best_cnt),
    .best_xy  (best_xy)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy <= 1'b0;
      DONE <= 1'b0;
      C1X  <= '0;
      C1Y  <= '0;
      C2X  <= '0;
      C2Y  <= '0;
    end else begin
      DONE <= fin;
      if (accept) begin
        busy <= 1'b1;
        C1X  <= '0;
        C1Y  <= '0;
        C2X  <= '0;
        C2Y  <= '0;
      end else if (fin) begin
        busy <= 1'b0;
        C1X  <= c1.x;
        C1Y  <= c1.y;
        C2X  <= c2.x;
        C2Y  <= c2.y;
      end
    end
  end

  assign pt_addr  = pt;
  assign cand_x   = cand.x;
  assign cand_y   = cand.y;
  assign fixed_x  = pass[0] ? c1.x : c2.x;
  assign fixed_y  = pass[0] ? c1.y : c2.y;
  assign fixed_en = |pass;

endmodule
